sprite_draw_sequencer: RTL and testbench
========================================

Name: sprite_draw_sequencer

Overview:
- Upstream stage of draw_sprite: holds the game's object table (ship, asteroids, bullets) and schedules one draw_sprite job per active object per frame.
- Each frame runs two passes: an erase pass that redraws every previous position with erase asserted (colour forced to black downstream), then a draw pass at the current positions.
- Jobs are serialized with a plot pulse / draw_done handshake.

Parameters:
- NUM_OBJ, 8, number of object slots.
- IDX_W, 3, slot index width (clog2 of NUM_OBJ).
- COORD_W, 10, x/y coordinate width.
- SPR_W, 2, sprite-select width (ROM image id).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- obj_we  in  1  write one slot of the live table.
- obj_idx  in  IDX_W  slot written.
- obj_x  in  COORD_W  top-left x.
- obj_y  in  COORD_W  top-left y.
- obj_spr  in  SPR_W  sprite id.
- obj_active  in  1  slot visible.
- frame_tick  in  1  one-cycle start-of-frame request.
- draw_done  in  1  level from draw_sprite, high while it is idle.
- plot  out  1  one-cycle job start to draw_sprite.
- x_pos  out  COORD_W  job x.
- y_pos  out  COORD_W  job y.
- spr_sel  out  SPR_W  job sprite id.
- erase  out  1  current job is an erase.
- busy  out  1  high from frame accept until frame_done.
- frame_done  out  1  one-cycle pulse at end of frame.
- frame_overrun  out  1  one-cycle pulse when frame_tick arrives while busy.

Behaviour:
- Reset (async, reset_n=0):
  - All live/cur/prev active bits = 0; coordinates and sprite ids = 0.
  - State S_IDLE, index = 0.
  - plot, erase, busy, frame_done, frame_overrun = 0; x_pos, y_pos, spr_sel = 0.
  - Reset mid-frame abandons the frame immediately; no further plot is issued.
- Tables: live (written by obj_we), cur (snapshot), prev (last drawn).
  - obj_we updates live[obj_idx] on the clock edge, in any state.
- S_IDLE:
  - On frame_tick: cur <= live (whole table, same edge), index <= 0, busy <= 1, go to S_E_ISSUE.
  - If obj_we and frame_tick occur in the same cycle, the snapshot takes the pre-write value; the write appears next frame.
- S_E_ISSUE (erase pass):
  - If prev[index].active: drive x_pos/y_pos/spr_sel from prev[index], erase=1, plot=1 for exactly this cycle, go to S_E_WLO.
  - Otherwise skip the slot (one cycle, no plot).
  - After slot NUM_OBJ-1 (issued or skipped): index <= 0, go to S_D_ISSUE.
- S_E_WLO: wait until draw_done==0, then go to S_E_WHI.
- S_E_WHI: wait until draw_done==1, then index+1 (or the pass change above).
- S_D_ISSUE / S_D_WLO / S_D_WHI (draw pass): same as the erase pass, with these differences:
  - Uses cur[index] and erase=0.
  - On completion of slot i (draw_done rising in S_D_WHI, or skip of an inactive slot): prev[i] <= cur[i], so inactive slots also clear prev.
- After the last draw slot: go to S_DONE.
- S_DONE: frame_done=1 for one cycle, busy <= 0, back to S_IDLE.
- Output hold: x_pos, y_pos, spr_sel and erase are registered and hold steady from the plot cycle until the next issue. draw_sprite samples them throughout the job.
- frame_tick when not in S_IDLE: ignored (no snapshot); frame_overrun pulses the following cycle.
- Latency:
  - frame_tick to first plot: 2 cycles (snapshot edge, then issue).
  - An all-inactive frame takes 2*NUM_OBJ+2 cycles from tick to frame_done.
- Index arithmetic: unsigned IDX_W bits. The terminal test is index==NUM_OBJ-1; wrap is never used as the end condition.
- Handshake rule: plot is never asserted unless draw_done==1 in the same cycle. If draw_done is low in an ISSUE state, the state holds without plotting.

Decomposition:
- Shared package (draw_pkg): state encodings; COORD_W, SPR_W; sprite-id constants (SPR_SHIP, SPR_AST_L, SPR_AST_S, SPR_BULLET).
- Sub-module: sprite_obj_table, holding the live/cur/prev arrays, snapshot and commit-to-prev enables, and a read mux selected by index and pass.
- The FSM stays in sprite_draw_sequencer.

Test Plan:
- Reset then a single tick with all slots inactive -> no plot; frame_done exactly 18 cycles after the tick for NUM_OBJ=8; busy high for those cycles.
- Write slot 2 (x=100, y=50, spr=1, active) and tick; behavioural draw_sprite model (done low 20 cycles) -> one plot with erase=0, x_pos=100, y_pos=50, spr_sel=1; no erase job.
- Move slot 2 to x=120 and tick -> first plot erase=1 at (100,50), then plot erase=0 at (120,50); the next frame erases (120,50).
- Deactivate slot 2 and tick -> erase at (120,50) only; a following tick -> no plots at all.
- Tick while busy -> frame_overrun pulses once; job sequence unchanged; obj_we coincident with an accepted tick is not drawn until the next frame.
- Assert reset_n=0 during S_D_WHI -> outputs 0 asynchronously; after release, a tick produces no erase jobs (prev cleared).

Source files
------------

// File: rtl/draw_pkg.sv
// Shared definitions for the sprite drawing pipeline: table sizing,
// coordinate widths, ROM sprite ids and the sequencer state encoding.
package draw_pkg;

    localparam int NUM_OBJ = 8;
    localparam int IDX_W   = 3;
    localparam int COORD_W = 10;
    localparam int SPR_W   = 2;

    // Sprite ROM image ids
    localparam logic [SPR_W-1:0] SPR_SHIP   = 2'd0;
    localparam logic [SPR_W-1:0] SPR_AST_L  = 2'd1;
    localparam logic [SPR_W-1:0] SPR_AST_S  = 2'd2;
    localparam logic [SPR_W-1:0] SPR_BULLET = 2'd3;

    // Sequencer states: erase pass (E_*) then draw pass (D_*)
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_E_ISSUE = 3'd1,
        S_E_WLO   = 3'd2,
        S_E_WHI   = 3'd3,
        S_D_ISSUE = 3'd4,
        S_D_WLO   = 3'd5,
        S_D_WHI   = 3'd6,
        S_DONE    = 3'd7
    } seq_state_t;

endpackage

// File: rtl/sprite_obj_table.sv
// Object table for the sprite sequencer. Holds three copies of every slot:
// live (written by the game at any time), cur (frame snapshot being drawn)
// and prev (what is currently on screen, used by the erase pass).
module sprite_obj_table
    import draw_pkg::*;
#(
    parameter int N_OBJ = NUM_OBJ,
    parameter int I_W   = IDX_W,
    parameter int C_W   = COORD_W,
    parameter int S_W   = SPR_W
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           we,
    input  logic [I_W-1:0] wr_idx,
    input  logic [C_W-1:0] wr_x,
    input  logic [C_W-1:0] wr_y,
    input  logic [S_W-1:0] wr_spr,
    input  logic           wr_active,
    input  logic           snapshot,
    input  logic           commit,
    input  logic [I_W-1:0] rd_idx,
    input  logic           rd_draw,
    output logic [C_W-1:0] rd_x,
    output logic [C_W-1:0] rd_y,
    output logic [S_W-1:0] rd_spr,
    output logic           rd_active
);

    logic [C_W-1:0] live_x   [N_OBJ];
    logic [C_W-1:0] live_y   [N_OBJ];
    logic [S_W-1:0] live_spr [N_OBJ];
    logic           live_act [N_OBJ];
    logic [C_W-1:0] cur_x    [N_OBJ];
    logic [C_W-1:0] cur_y    [N_OBJ];
    logic [S_W-1:0] cur_spr  [N_OBJ];
    logic           cur_act  [N_OBJ];
    logic [C_W-1:0] prev_x   [N_OBJ];
    logic [C_W-1:0] prev_y   [N_OBJ];
    logic [S_W-1:0] prev_spr [N_OBJ];
    logic           prev_act [N_OBJ];

    // Live table: game writes land on the edge; a snapshot on the same edge
    // still copies the old value because cur reads live before the update.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_OBJ; i++) begin
                live_x[i]   <= '0;
                live_y[i]   <= '0;
                live_spr[i] <= '0;
                live_act[i] <= 1'b0;
            end
        end else if (we) begin
            live_x[wr_idx]   <= wr_x;
            live_y[wr_idx]   <= wr_y;
            live_spr[wr_idx] <= wr_spr;
            live_act[wr_idx] <= wr_active;
        end
    end

    // Frame snapshot: whole live table copied into cur at frame accept.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_OBJ; i++) begin
                cur_x[i]   <= '0;
                cur_y[i]   <= '0;
                cur_spr[i] <= '0;
                cur_act[i] <= 1'b0;
            end
        end else if (snapshot) begin
            for (int i = 0; i < N_OBJ; i++) begin
                cur_x[i]   <= live_x[i];
                cur_y[i]   <= live_y[i];
                cur_spr[i] <= live_spr[i];
                cur_act[i] <= live_act[i];
            end
        end
    end

    // Commit of a finished draw slot (at the read index) so the next frame
    // erases exactly what was drawn; inactive slots clear their prev entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_OBJ; i++) begin
                prev_x[i]   <= '0;
                prev_y[i]   <= '0;
                prev_spr[i] <= '0;
                prev_act[i] <= 1'b0;
            end
        end else if (commit) begin
            prev_x[rd_idx]   <= cur_x[rd_idx];
            prev_y[rd_idx]   <= cur_y[rd_idx];
            prev_spr[rd_idx] <= cur_spr[rd_idx];
            prev_act[rd_idx] <= cur_act[rd_idx];
        end
    end

    // Read mux: the draw pass reads the snapshot, the erase pass reads prev.
    always_comb begin
        rd_x      = prev_x[rd_idx];
        rd_y      = prev_y[rd_idx];
        rd_spr    = prev_spr[rd_idx];
        rd_active = prev_act[rd_idx];
        if (rd_draw) begin
            rd_x      = cur_x[rd_idx];
            rd_y      = cur_y[rd_idx];
            rd_spr    = cur_spr[rd_idx];
            rd_active = cur_act[rd_idx];
        end
    end

endmodule

// File: rtl/sprite_draw_sequencer.sv
// Frame sequencer in front of draw_sprite: each frame erases every object
// at its previous position, then draws every active object at its current
// position, one job at a time through the plot / draw_done handshake.
module sprite_draw_sequencer
    import draw_pkg::*;
#(
    parameter int NUM_OBJ = draw_pkg::NUM_OBJ,
    parameter int IDX_W   = draw_pkg::IDX_W,
    parameter int COORD_W = draw_pkg::COORD_W,
    parameter int SPR_W   = draw_pkg::SPR_W
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               obj_we,
    input  logic [IDX_W-1:0]   obj_idx,
    input  logic [COORD_W-1:0] obj_x,
    input  logic [COORD_W-1:0] obj_y,
    input  logic [SPR_W-1:0]   obj_spr,
    input  logic               obj_active,
    input  logic               frame_tick,
    input  logic               draw_done,
    output logic               plot,
    output logic [COORD_W-1:0] x_pos,
    output logic [COORD_W-1:0] y_pos,
    output logic [SPR_W-1:0]   spr_sel,
    output logic               erase,
    output logic               busy,
    output logic               frame_done,
    output logic               frame_overrun
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OBJ - 1);

    seq_state_t         state, state_n;
    logic [IDX_W-1:0]   index, index_n;
    logic               plot_n, erase_n, busy_n, done_n, overrun_n;
    logic [COORD_W-1:0] x_n, y_n;
    logic [SPR_W-1:0]   spr_n;
    logic               snapshot, commit, rd_draw;
    logic [COORD_W-1:0] rd_x, rd_y;
    logic [SPR_W-1:0]   rd_spr;
    logic               rd_active;

    assign rd_draw = (state == S_D_ISSUE) || (state == S_D_WLO) || (state == S_D_WHI);

    sprite_obj_table #(
        .N_OBJ (NUM_OBJ),
        .I_W   (IDX_W),
        .C_W   (COORD_W),
        .S_W   (SPR_W)
    ) u_table (
        .clk       (clk),
        .reset_n   (reset_n),
        .we        (obj_we),
        .wr_idx    (obj_idx),
        .wr_x      (obj_x),
        .wr_y      (obj_y),
        .wr_spr    (obj_spr),
        .wr_active (obj_active),
        .snapshot  (snapshot),
        .commit    (commit),
        .rd_idx    (index),
        .rd_draw   (rd_draw),
        .rd_x      (rd_x),
        .rd_y      (rd_y),
        .rd_spr    (rd_spr),
        .rd_active (rd_active)
    );

    // State, slot index and all registered outputs; reset abandons a frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            index         <= '0;
            plot          <= 1'b0;
            erase         <= 1'b0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
            frame_overrun <= 1'b0;
            x_pos         <= '0;
            y_pos         <= '0;
            spr_sel       <= '0;
        end else begin
            state         <= state_n;
            index         <= index_n;
            plot          <= plot_n;
            erase         <= erase_n;
            busy          <= busy_n;
            frame_done    <= done_n;
            frame_overrun <= overrun_n;
            x_pos         <= x_n;
            y_pos         <= y_n;
            spr_sel       <= spr_n;
        end
    end

    // Next state and next outputs. Job fields are only reloaded on issue so
    // draw_sprite sees them stable for the whole job. A slot is only issued
    // while draw_done is high, otherwise the issue state holds.
    always_comb begin
        state_n   = state;
        index_n   = index;
        plot_n    = 1'b0;
        erase_n   = erase;
        busy_n    = busy;
        done_n    = 1'b0;
        overrun_n = frame_tick && (state != S_IDLE);
        x_n       = x_pos;
        y_n       = y_pos;
        spr_n     = spr_sel;
        snapshot  = 1'b0;
        commit    = 1'b0;

        case (state)
            S_IDLE: begin
                if (frame_tick) begin
                    snapshot = 1'b1;
                    index_n  = '0;
                    busy_n   = 1'b1;
                    state_n  = S_E_ISSUE;
                end
            end
            S_E_ISSUE: begin
                if (draw_done) begin
                    if (rd_active) begin
                        plot_n  = 1'b1;
                        erase_n = 1'b1;
                        x_n     = rd_x;
                        y_n     = rd_y;
                        spr_n   = rd_spr;
                        state_n = S_E_WLO;
                    end else if (index == LAST_IDX) begin
                        index_n = '0;
                        state_n = S_D_ISSUE;
                    end else begin
                        index_n = index + IDX_W'(1);
                    end
                end
            end
            S_E_WLO: begin
                if (!draw_done) state_n = S_E_WHI;
            end
            S_E_WHI: begin
                if (draw_done) begin
                    if (index == LAST_IDX) begin
                        index_n = '0;
                        state_n = S_D_ISSUE;
                    end else begin
                        index_n = index + IDX_W'(1);
                        state_n = S_E_ISSUE;
                    end
                end
            end
            S_D_ISSUE: begin
                if (draw_done) begin
                    if (rd_active) begin
                        plot_n  = 1'b1;
                        erase_n = 1'b0;
                        x_n     = rd_x;
                        y_n     = rd_y;
                        spr_n   = rd_spr;
                        state_n = S_D_WLO;
                    end else begin
                        commit = 1'b1;
                        if (index == LAST_IDX) begin
                            index_n = '0;
                            state_n = S_DONE;
                        end else begin
                            index_n = index + IDX_W'(1);
                        end
                    end
                end
            end
            S_D_WLO: begin
                if (!draw_done) state_n = S_D_WHI;
            end
            S_D_WHI: begin
                if (draw_done) begin
                    commit = 1'b1;
                    if (index == LAST_IDX) begin
                        index_n = '0;
                        state_n = S_DONE;
                    end else begin
                        index_n = index + IDX_W'(1);
                        state_n = S_D_ISSUE;
                    end
                end
            end
            S_DONE: begin
                done_n  = 1'b1;
                busy_n  = 1'b0;
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sprite_draw_sequencer.sv
// Directed bench for sprite_draw_sequencer with a behavioural draw_sprite
// (draw_done low for 20 cycles per job) and a job log of every plot.
module tb_sprite_draw_sequencer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       obj_we;
    logic [2:0] obj_idx;
    logic [9:0] obj_x, obj_y;
    logic [1:0] obj_spr;
    logic       obj_active;
    logic       frame_tick;
    logic       draw_done;
    logic       plot;
    logic [9:0] x_pos, y_pos;
    logic [1:0] spr_sel;
    logic       erase, busy, frame_done, frame_overrun;

    typedef struct {
        logic       er;
        logic [9:0] x;
        logic [9:0] y;
        logic [1:0] s;
        int         cyc;
    } job_t;

    job_t jobs[$];
    int   num_checks = 0;
    int   num_errors = 0;
    int   cyc = 0;
    int   tick_cyc = 0;
    int   ov_cnt = 0;
    int   hs_viol = 0;
    int   busy_cycles;
    int   frame_len;
    int   done_cnt = 0;

    sprite_draw_sequencer dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .obj_we        (obj_we),
        .obj_idx       (obj_idx),
        .obj_x         (obj_x),
        .obj_y         (obj_y),
        .obj_spr       (obj_spr),
        .obj_active    (obj_active),
        .frame_tick    (frame_tick),
        .draw_done     (draw_done),
        .plot          (plot),
        .x_pos         (x_pos),
        .y_pos         (y_pos),
        .spr_sel       (spr_sel),
        .erase         (erase),
        .busy          (busy),
        .frame_done    (frame_done),
        .frame_overrun (frame_overrun)
    );

    always #5 clk = ~clk;

    // Cycle counter, handshake watchdog and draw_sprite busy model
    initial draw_done = 1'b1;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (plot && !draw_done) hs_viol <= hs_viol + 1;
        if (done_cnt > 0) begin
            done_cnt <= done_cnt - 1;
            if (done_cnt == 1) draw_done <= 1'b1;
        end else if (plot) begin
            draw_done <= 1'b0;
            done_cnt  <= 20;
        end
    end

    // Job log and overrun pulse counter, sampled mid-cycle
    always @(negedge clk) begin
        if (plot) jobs.push_back('{er: erase, x: x_pos, y: y_pos, s: spr_sel, cyc: cyc});
        if (frame_overrun) ov_cnt = ov_cnt + 1;
    end

    function automatic logic [31:0] pack(input logic er, input logic [9:0] x,
                                         input logic [9:0] y, input logic [1:0] s);
        return {9'd0, er, x, y, s};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        num_checks++;
        if (got !== exp) begin
            num_errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic checkJob(input string tag, input int k, input logic [31:0] exp);
        logic [31:0] got;
        got = 32'hFFFF_FFFF;
        if (k < jobs.size()) got = pack(jobs[k].er, jobs[k].x, jobs[k].y, jobs[k].s);
        checkOutput(tag, got, exp);
    endtask

    task automatic applyStimulus(input logic [2:0] idx, input logic [9:0] x, input logic [9:0] y,
                                 input logic [1:0] s, input logic act);
        @(negedge clk);
        obj_we = 1'b1; obj_idx = idx; obj_x = x; obj_y = y; obj_spr = s; obj_active = act;
        @(negedge clk);
        obj_we = 1'b0;
    endtask

    // Pulse frame_tick (optionally with a coincident write already set up
    // on obj_*), optionally re-tick at cycle ov_at, and wait for frame_done.
    task automatic tickAndWait(input int ov_at, input logic co_we);
        logic got;
        got = 1'b0;
        jobs.delete();
        ov_cnt = 0;
        busy_cycles = 0;
        frame_len = 0;
        @(negedge clk);
        frame_tick = 1'b1;
        obj_we = co_we;
        tick_cyc = cyc;
        while (frame_len < 2000 && !got) begin
            @(negedge clk);
            frame_len++;
            frame_tick = (frame_len == ov_at);
            obj_we = 1'b0;
            if (frame_done) got = 1'b1;
            else if (busy) busy_cycles++;
        end
        checkOutput("frame_done_seen", {31'd0, got}, 32'd1);
        checkOutput("busy_at_done", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int waited;
        reset_n = 1'b0; obj_we = 1'b0; obj_idx = '0; obj_x = '0; obj_y = '0;
        obj_spr = '0; obj_active = 1'b0; frame_tick = 1'b0;
        #12;
        checkOutput("reset_outputs", {13'd0, plot, erase, busy, frame_done, frame_overrun,
                    x_pos, y_pos, spr_sel}, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        $display("[TB] all-inactive frame");
        tickAndWait(0, 1'b0);
        checkOutput("empty_frame_len", frame_len, 32'd18);
        checkOutput("empty_busy_cycles", busy_cycles, 32'd17);
        checkOutput("empty_jobs", jobs.size(), 32'd0);

        $display("[TB] first draw of slot 2");
        applyStimulus(3'd2, 10'd100, 10'd50, 2'd1, 1'b1);
        tickAndWait(0, 1'b0);
        checkOutput("draw1_jobs", jobs.size(), 32'd1);
        checkJob("draw1_job0", 0, pack(1'b0, 10'd100, 10'd50, 2'd1));

        $display("[TB] move slot 2");
        applyStimulus(3'd2, 10'd120, 10'd50, 2'd1, 1'b1);
        tickAndWait(0, 1'b0);
        checkOutput("move_jobs", jobs.size(), 32'd2);
        checkJob("move_erase", 0, pack(1'b1, 10'd100, 10'd50, 2'd1));
        checkJob("move_draw", 1, pack(1'b0, 10'd120, 10'd50, 2'd1));
        checkOutput("move_plot_latency", (jobs.size() > 0) ? jobs[0].cyc - tick_cyc : -1, 32'd4);

        tickAndWait(0, 1'b0);
        checkOutput("static_jobs", jobs.size(), 32'd2);
        checkJob("static_erase", 0, pack(1'b1, 10'd120, 10'd50, 2'd1));

        $display("[TB] deactivate slot 2");
        applyStimulus(3'd2, 10'd120, 10'd50, 2'd1, 1'b0);
        tickAndWait(0, 1'b0);
        checkOutput("deact_jobs", jobs.size(), 32'd1);
        checkJob("deact_erase", 0, pack(1'b1, 10'd120, 10'd50, 2'd1));
        tickAndWait(0, 1'b0);
        checkOutput("cleared_jobs", jobs.size(), 32'd0);
        checkOutput("cleared_frame_len", frame_len, 32'd18);

        $display("[TB] overrun and coincident write");
        applyStimulus(3'd5, 10'd200, 10'd300, 2'd2, 1'b1);
        @(negedge clk);
        obj_idx = 3'd6; obj_x = 10'd300; obj_y = 10'd400; obj_spr = 2'd3; obj_active = 1'b1;
        tickAndWait(5, 1'b1);
        checkOutput("overrun_pulses", ov_cnt, 32'd1);
        checkOutput("overrun_jobs", jobs.size(), 32'd1);
        checkJob("overrun_job0", 0, pack(1'b0, 10'd200, 10'd300, 2'd2));
        tickAndWait(0, 1'b0);
        checkOutput("next_overrun_pulses", ov_cnt, 32'd0);
        checkOutput("next_jobs", jobs.size(), 32'd3);
        checkJob("next_erase5", 0, pack(1'b1, 10'd200, 10'd300, 2'd2));
        checkJob("next_draw5", 1, pack(1'b0, 10'd200, 10'd300, 2'd2));
        checkJob("next_draw6", 2, pack(1'b0, 10'd300, 10'd400, 2'd3));

        $display("[TB] reset during draw wait");
        jobs.delete();
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        waited = 0;
        while (jobs.size() < 3 && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("reach_draw_job", jobs.size(), 32'd3);
        repeat (5) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("async_reset_outputs", {13'd0, plot, erase, busy, frame_done, frame_overrun,
                    x_pos, y_pos, spr_sel}, 32'd0);
        repeat (3) @(negedge clk);
        checkOutput("no_plot_in_reset", jobs.size(), 32'd3);
        reset_n = 1'b1;
        waited = 0;
        while (!draw_done && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("model_idle", {31'd0, draw_done}, 32'd1);
        applyStimulus(3'd1, 10'd10, 10'd20, 2'd3, 1'b1);
        tickAndWait(0, 1'b0);
        checkOutput("post_reset_jobs", jobs.size(), 32'd1);
        checkJob("post_reset_draw", 0, pack(1'b0, 10'd10, 10'd20, 2'd3));

        checkOutput("handshake_violations", hs_viol, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule
